tod_clock_mux: RTL and testbench

- Parametrised successor to the team's binary clock.
- Keeps a time-of-day counter (hours/minutes/seconds) driven by an internal prescaler from the single system clock `clk`. Fully synchronous: no derived or ripple clocks.
- Adds a field-wise time-set interface, a 12h/24h mode, an hour:minute alarm with sticky flag and acknowledge, and a programmable-dwell multiplexed 8-bit display output for the pad ring.

---
 rtl/tod_clock_mux.sv | 181 ++++++++++++++++++
 tb/tb_tod_clock_mux.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tod_clock_mux.sv
// Time-of-day counter with prescaler, field-wise set port, 12h/24h hours, hour:minute alarm
// and a dwell-programmable multiplexed display output, all in the single clk domain.
`timescale 1ns/1ps

module tod_clock_mux #(
    parameter int TICK_DIV = 100,
    parameter bit MODE_12H = 1'b0,
    parameter int DWELL    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       set_valid,
    input  logic [1:0] set_sel,
    input  logic [5:0] set_value,
    output logic       set_err,
    input  logic       alarm_en,
    input  logic [4:0] alarm_h,
    input  logic [5:0] alarm_m,
    input  logic       alarm_ack,
    output logic       alarm,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       sec_tick,
    output logic [7:0] disp,
    output logic [1:0] disp_sel
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    localparam logic [4:0] HOUR_FIRST = MODE_12H ? 5'd1 : 5'd0;
    localparam logic [4:0] HOUR_LAST  = MODE_12H ? 5'd12 : 5'd23;
    localparam logic [4:0] HOUR_RESET = MODE_12H ? 5'd12 : 5'd0;
    localparam logic [5:0] HOUR_BASE  = {1'b0, HOUR_FIRST};
    localparam logic [5:0] HOUR_SPAN  = {1'b0, HOUR_LAST} - {1'b0, HOUR_FIRST};

    localparam logic [1:0] SEL_HOURS   = 2'd0;
    localparam logic [1:0] SEL_MINUTES = 2'd1;
    localparam logic [1:0] SEL_SECONDS = 2'd2;

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    minutes_q, minutes_d;
    logic [5:0]    seconds_q, seconds_d;
    logic          secTick_q, secTick_d;
    logic          setErr_q, setErr_d;
    logic          alarm_q, alarm_d;
    logic [DW-1:0] dwellCnt_q, dwellCnt_d;
    logic [1:0]    dispSel_q, dispSel_d;

    logic inRange;
    logic writeOk;
    logic secWrite;
    logic tickDue;
    logic advance;
    logic alarmMatch;

    // Hours range check wraps below HOUR_FIRST to a large value, so one compare covers both bounds.
    always_comb begin
        case (set_sel)
            2'd0:       inRange = (set_value - HOUR_BASE) <= HOUR_SPAN;
            2'd1, 2'd2: inRange = set_value <= 6'd59;
            default:    inRange = 1'b0;
        endcase
    end

    assign writeOk  = set_valid && inRange;
    assign secWrite = writeOk && (set_sel == 2'd2);
    assign tickDue  = en && (prescaler_q == PRE_LAST);
    assign advance  = tickDue && !writeOk;

    always_comb begin
        prescaler_d = prescaler_q;
        if (en) begin
            prescaler_d = tickDue ? '0 : prescaler_q + PW'(1);
        end
        if (secWrite) begin
            prescaler_d = '0;
        end
    end

    // An accepted write owns the edge; a second that falls due on it is discarded.
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        if (writeOk) begin
            case (set_sel)
                2'd0:    hours_d   = set_value[4:0];
                2'd1:    minutes_d = set_value;
                default: seconds_d = set_value;
            endcase
        end else if (advance) begin
            if (seconds_q == 6'd59) begin
                seconds_d = 6'd0;
                if (minutes_q == 6'd59) begin
                    minutes_d = 6'd0;
                    hours_d   = (hours_q == HOUR_LAST) ? HOUR_FIRST : hours_q + 5'd1;
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end
    end

    always_comb begin
        alarmMatch = advance && alarm_en && (hours_d == alarm_h) &&
                     (minutes_d == alarm_m) && (seconds_d == 6'd0);
        secTick_d  = advance;
        setErr_d   = set_valid && !inRange;
        if (alarmMatch) begin
            alarm_d = 1'b1;
        end else if (alarm_ack) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end
    end

    // Display scan free-runs regardless of en so the pad ring never stalls on one field.
    always_comb begin
        dwellCnt_d = dwellCnt_q + DW'(1);
        dispSel_d  = dispSel_q;
        if (dwellCnt_q == DWELL_LAST) begin
            dwellCnt_d = '0;
            case (dispSel_q)
                SEL_HOURS:   dispSel_d = SEL_MINUTES;
                SEL_MINUTES: dispSel_d = SEL_SECONDS;
                default:     dispSel_d = SEL_HOURS;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
            hours_q     <= HOUR_RESET;
            minutes_q   <= 6'd0;
            seconds_q   <= 6'd0;
            secTick_q   <= 1'b0;
            setErr_q    <= 1'b0;
            alarm_q     <= 1'b0;
            dwellCnt_q  <= '0;
            dispSel_q   <= SEL_HOURS;
        end else begin
            prescaler_q <= prescaler_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            secTick_q   <= secTick_d;
            setErr_q    <= setErr_d;
            alarm_q     <= alarm_d;
            dwellCnt_q  <= dwellCnt_d;
            dispSel_q   <= dispSel_d;
        end
    end

    always_comb begin
        case (dispSel_q)
            SEL_HOURS:   disp = {3'b000, hours_q};
            SEL_MINUTES: disp = {2'b00, minutes_q};
            default:     disp = {2'b00, seconds_q};
        endcase
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign sec_tick = secTick_q;
    assign set_err  = setErr_q;
    assign alarm    = alarm_q;
    assign disp_sel = dispSel_q;

endmodule

// File: tb/tb_tod_clock_mux.sv
// Scoreboard bench for tod_clock_mux: a 24h instance and a 12h instance share stimulus and are
// checked every cycle against a seconds-of-day reference model.
`timescale 1ns/1ps

module tb_tod_clock_mux;

    localparam int TD24 = 4;
    localparam int DW24 = 2;
    localparam int TD12 = 3;
    localparam int DW12 = 1;

    typedef struct packed {
        int h;
        int m;
        int s;
        int pre;
        int edges;
        bit tick;
        bit err;
        bit alarm;
    } model_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       set_valid = 1'b0;
    logic [1:0] set_sel = 2'd0;
    logic [5:0] set_value = 6'd0;
    logic       alarm_en = 1'b0;
    logic [4:0] alarmH24 = 5'd0;
    logic [4:0] alarmH12 = 5'd0;
    logic [5:0] alarm_m = 6'd0;
    logic       alarm_ack = 1'b0;

    logic       setErr24, alarm24, secTick24;
    logic [4:0] hours24;
    logic [5:0] minutes24, seconds24;
    logic [7:0] disp24;
    logic [1:0] dispSel24;

    logic       setErr12, alarm12, secTick12;
    logic [4:0] hours12;
    logic [5:0] minutes12, seconds12;
    logic [7:0] disp12;
    logic [1:0] dispSel12;

    int testsRun = 0;
    int testsFailed = 0;

    model_t m24, m12s;
    model_t q24[$];
    model_t q12[$];

    bit aenV = 1'b0;
    int ah24V = 0;
    int ah12V = 0;
    int amV = 0;

    always #5 clk = ~clk;

    tod_clock_mux #(.TICK_DIV(TD24), .MODE_12H(1'b0), .DWELL(DW24)) dut24 (
        .clk(clk), .rst(rst), .en(en),
        .set_valid(set_valid), .set_sel(set_sel), .set_value(set_value), .set_err(setErr24),
        .alarm_en(alarm_en), .alarm_h(alarmH24), .alarm_m(alarm_m), .alarm_ack(alarm_ack),
        .alarm(alarm24), .hours(hours24), .minutes(minutes24), .seconds(seconds24),
        .sec_tick(secTick24), .disp(disp24), .disp_sel(dispSel24)
    );

    tod_clock_mux #(.TICK_DIV(TD12), .MODE_12H(1'b1), .DWELL(DW12)) dut12 (
        .clk(clk), .rst(rst), .en(en),
        .set_valid(set_valid), .set_sel(set_sel), .set_value(set_value), .set_err(setErr12),
        .alarm_en(alarm_en), .alarm_h(alarmH12), .alarm_m(alarm_m), .alarm_ack(alarm_ack),
        .alarm(alarm12), .hours(hours12), .minutes(minutes12), .seconds(seconds12),
        .sec_tick(secTick12), .disp(disp12), .disp_sel(dispSel12)
    );

    function automatic model_t modelReset(bit m12);
        model_t r;
        r = '0;
        r.h = m12 ? 12 : 0;
        return r;
    endfunction

    // Time is handled as seconds into the day (or half-day) and decoded back into fields.
    function automatic model_t modelStep(model_t c, bit m12, int td, bit enV, bit sv,
                                         int sel, int val, bit aen, int ah, int am, bit ack);
        model_t n;
        bit okRange, accept, due, matched;
        int span, t;
        n = c;
        n.tick = 1'b0;
        n.edges = c.edges + 1;
        matched = 1'b0;
        case (sel)
            0:       okRange = m12 ? (val >= 1 && val <= 12) : (val <= 23);
            1, 2:    okRange = (val <= 59);
            default: okRange = 1'b0;
        endcase
        accept = sv && okRange;
        n.err = sv && !okRange;
        due = enV && (c.pre == td - 1);
        if (enV) n.pre = due ? 0 : c.pre + 1;
        if (accept) begin
            case (sel)
                0:       n.h = val;
                1:       n.m = val;
                default: begin n.s = val; n.pre = 0; end
            endcase
        end else if (due) begin
            span = m12 ? 12 * 3600 : 24 * 3600;
            t = ((m12 ? c.h % 12 : c.h) * 3600 + c.m * 60 + c.s + 1) % span;
            n.h = t / 3600;
            if (m12 && n.h == 0) n.h = 12;
            n.m = (t / 60) % 60;
            n.s = t % 60;
            n.tick = 1'b1;
            matched = aen && (n.h == ah) && (n.m == am) && (n.s == 0);
        end
        n.alarm = matched ? 1'b1 : (ack ? 1'b0 : c.alarm);
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        testsRun++;
        if (act !== 32'(exp)) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input model_t e, input int dw,
                               input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                               input logic tick, input logic err, input logic al,
                               input logic [1:0] sel, input logic [7:0] d);
        int eSel, eDisp;
        eSel = (e.edges / dw) % 3;
        eDisp = (eSel == 0) ? e.h : ((eSel == 1) ? e.m : e.s);
        check({tag, " hours"}, 32'(h), e.h);
        check({tag, " minutes"}, 32'(m), e.m);
        check({tag, " seconds"}, 32'(s), e.s);
        check({tag, " sec_tick"}, 32'(tick), int'(e.tick));
        check({tag, " set_err"}, 32'(err), int'(e.err));
        check({tag, " alarm"}, 32'(al), int'(e.alarm));
        check({tag, " disp_sel"}, 32'(sel), eSel);
        check({tag, " disp"}, 32'(d), eDisp);
    endtask

    task automatic pushExpected();
        q24.push_back(m24);
        q12.push_back(m12s);
    endtask

    task automatic applyStimulus(input bit enV, input bit sv, input int sel, input int val,
                                 input bit ack);
        @(negedge clk);
        rst = 1'b0;
        en = enV;
        set_valid = sv;
        set_sel = 2'(sel);
        set_value = 6'(val);
        alarm_en = aenV;
        alarmH24 = 5'(ah24V);
        alarmH12 = 5'(ah12V);
        alarm_m = 6'(amV);
        alarm_ack = ack;
        m24 = modelStep(m24, 1'b0, TD24, enV, sv, sel, val, aenV, ah24V, amV, ack);
        m12s = modelStep(m12s, 1'b1, TD12, enV, sv, sel, val, aenV, ah12V, amV, ack);
        pushExpected();
    endtask

    task automatic idle(input int n, input bit enV);
        for (int i = 0; i < n; i++) applyStimulus(enV, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic writeField(input int sel, input int val);
        applyStimulus(1'b1, 1'b1, sel, val, 1'b0);
    endtask

    task automatic waitDue24();
        for (int i = 0; i < 8 && m24.pre != TD24 - 1; i++) idle(1, 1'b1);
        check("due24 reached", 32'(m24.pre), TD24 - 1);
    endtask

    // Reset lands between edges so the outputs must change without a clk edge.
    task automatic asyncReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst hours24", 32'(hours24), 0);
        check("async rst minutes24", 32'(minutes24), 0);
        check("async rst seconds24", 32'(seconds24), 0);
        check("async rst disp_sel24", 32'(dispSel24), 0);
        check("async rst alarm24", 32'(alarm24), 0);
        check("async rst hours12", 32'(hours12), 12);
        check("async rst disp_sel12", 32'(dispSel12), 0);
        m24 = modelReset(1'b0);
        m12s = modelReset(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_valid = 1'b0;
            alarm_ack = 1'b0;
            pushExpected();
        end
    endtask

    initial begin : monitor
        model_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q24.size() > 0) begin
                e = q24.pop_front();
                checkOutput("dut24", e, DW24, hours24, minutes24, seconds24, secTick24,
                            setErr24, alarm24, dispSel24, disp24);
            end
            if (q12.size() > 0) begin
                e = q12.pop_front();
                checkOutput("dut12", e, DW12, hours12, minutes12, seconds12, secTick12,
                            setErr12, alarm12, dispSel12, disp12);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int sel, val;
        bit sv, enV, ack;
        m24 = modelReset(1'b0);
        m12s = modelReset(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pushExpected();
        end

        // Free-running advance across a minute boundary.
        idle(245, 1'b1);

        // Wrap of the last second of the day / half-day.
        writeField(0, 12);
        writeField(1, 59);
        writeField(2, 59);
        idle(6, 1'b1);
        writeField(0, 23);
        writeField(1, 59);
        writeField(2, 59);
        idle(6, 1'b1);

        // Rejected writes and a write colliding with a due advance.
        writeField(1, 60);
        idle(2, 1'b1);
        writeField(3, 5);
        idle(2, 1'b1);
        writeField(2, 63);
        waitDue24();
        writeField(0, 7);
        idle(3, 1'b1);

        // Alarm set, persist, acknowledge, then acknowledge on a matching edge.
        aenV = 1'b1; ah24V = 0; ah12V = 12; amV = 1;
        writeField(0, 0);
        writeField(1, 0);
        writeField(2, 59);
        idle(30, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
        idle(4, 1'b1);
        writeField(1, 0);
        writeField(2, 59);
        waitDue24();
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
        idle(4, 1'b1);

        // Freeze mid-second, then resume.
        idle(2, 1'b1);
        idle(50, 1'b0);
        idle(10, 1'b1);

        // Display scan over a fixed time.
        writeField(0, 5);
        writeField(1, 17);
        writeField(2, 42);
        idle(12, 1'b0);
        asyncReset();

        for (int c = 0; c < 1500; c++) begin
            if (c % 200 == 0) begin
                aenV = ($urandom_range(0, 3) != 0);
                ah24V = m24.h;
                ah12V = m12s.h;
                amV = ((c / 200) % 2 == 0) ? (m24.m + 1) % 60 : (m12s.m + 1) % 60;
            end
            if (c == 750) asyncReset();
            enV = ($urandom_range(0, 9) != 0);
            sv = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       val = $urandom_range(0, 63);
                1:       val = $urandom_range(55, 59);
                2:       val = $urandom_range(0, 12);
                default: val = $urandom_range(0, 59);
            endcase
            ack = ($urandom_range(0, 15) == 0);
            applyStimulus(enV, sv, sel, val, ack);
        end

        @(posedge clk);
        #2;
        check("scoreboard drained 24", 32'(q24.size()), 0);
        check("scoreboard drained 12", 32'(q12.size()), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
